// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a-b-bin (LSB first, one bit/cycle) with IDLE/RUN/DONE control; ports clk, rst, start, a, b, bin -> busy, done, diff, borrow_out (+ ovf when SUB_OVERFLOW_EN is defined)
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0] cnt;
  logic br, d, br_nx, last, accept;
  always_comb begin
    accept = state == IDLE && start;
    last = cnt == CW'(WIDTH - 1);
    d = a_sh[0] ^ b_sh[0] ^ br;
    br_nx = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res <= {d, res[WIDTH-1:1]};
      br <= br_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= {d, res[WIDTH-1:1]};
        borrow_out <= br_nx;
      end
    end
`ifdef SUB_OVERFLOW_EN
  logic a_msb, b_msb;
  always_ff @(posedge clk)
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN && last)
      ovf <= (a_msb != b_msb) && (d != a_msb);
`endif
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: table vectors, corner sequences and random scoreboard for WIDTH=8 and WIDTH=16
module tb_serial_subtractor_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, bin8 = 1'b0, start16 = 1'b0, bin16 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy8, done8, bo8, busy16, done16, bo16;
  logic [7:0] diff8;
  logic [15:0] diff16;
`ifdef SUB_OVERFLOW_EN
  logic ovf8, ovf16;
`endif
  int checks = 0, errors = 0, n_done8 = 0, n_done16 = 0;
  always #5 clk = ~clk;
  serial_subtractor_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );
  serial_subtractor_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );
  typedef struct {
    logic [7:0] a, b;
    logic bin;
    logic [7:0] d;
    logic bo, ov;
  } vec_t;
  vec_t tbl[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (busy8 && done8) chk("busy_done_excl8", 1, 0);
    if (busy16 && done16) chk("busy_done_excl16", 1, 0);
    if (done8) n_done8++;
    if (done16) n_done16++;
  end
  function automatic logic [32:0] ref_sub(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin);
    longint r = longint'(a) - longint'(b) - longint'(bin);
    return 33'(r & ((64'sd1 <<< (w + 1)) - 1));
  endfunction
  function automatic logic ref_ovf(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin);
    longint sa = a[w-1] ? longint'(a) - (64'sd1 <<< w) : longint'(a);
    longint sb = b[w-1] ? longint'(b) - (64'sd1 <<< w) : longint'(b);
    longint r = sa - sb - longint'(bin);
    return r > (64'sd1 <<< (w - 1)) - 1 || r < -(64'sd1 <<< (w - 1));
  endfunction
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic ebo, input logic eov);
    int lat = 0;
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = 1'b1;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; bin16 = bin; start16 = 1'b1;
    end
    tick();
    start8 = 1'b0;
    start16 = 1'b0;
    while ((w == 8 ? busy8 : busy16) && lat < 64) begin
      lat++;
      tick();
    end
    chk("latency", lat, w);
    chk("done", w == 8 ? done8 : done16, 1);
    chk("diff", w == 8 ? {8'h0, diff8} : diff16, ed);
    chk("borrow_out", w == 8 ? bo8 : bo16, ebo);
`ifdef SUB_OVERFLOW_EN
    chk("ovf", w == 8 ? ovf8 : ovf16, eov);
`endif
    tick();
    chk("done_drop", w == 8 ? done8 : done16, 0);
  endtask
  initial begin
    int base, lat;
    logic [31:0] ra, rb, mask;
    logic [32:0] full;
    logic rbin;
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tick();
    tick();
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_bo8", bo8, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_diff16", diff16, 0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf8", ovf8, 0);
`endif
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++)
      run_op(8, {24'h0, tbl[i].a}, {24'h0, tbl[i].b}, tbl[i].bin, {24'h0, tbl[i].d}, tbl[i].bo, tbl[i].ov);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'h00;
    lat = 0;
    while (busy8 && lat < 64) begin
      lat++;
      tick();
    end
    chk("held_latency", lat, 8);
    chk("held_done", done8, 1);
    chk("held_diff", diff8, 8'h02);
    tick();
    chk("held_idle_busy", busy8, 0);
    chk("held_idle_done", done8, 0);
    tick();
    chk("held_restart", busy8, 1);
    chk("diff_hold", diff8, 8'h02);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 64) begin
      lat++;
      tick();
    end
    chk("restart_diff", diff8, 8'hFF);
    tick();
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    chk("abort_in_run", busy8, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_bo", bo8, 0);
    base = n_done8;
    repeat (12) tick();
    chk("abort_no_done", n_done8 - base, 0);
    run_op(8, 32'h09, 32'h04, 1'b0, 32'h05, 1'b0, 1'b0);
    foreach (tbl[w]) begin end
    for (int w = 8; w <= 16; w += 8) begin
      mask = (32'd1 << w) - 1;
      base = w == 8 ? n_done8 : n_done16;
      for (int k = 0; k < 1000; k++) begin
        ra = $urandom & mask;
        rb = $urandom & mask;
        rbin = 1'($urandom_range(1, 0));
        full = ref_sub(w, ra, rb, rbin);
        run_op(w, ra, rb, rbin, full[31:0] & mask, full[w], ref_ovf(w, ra, rb, rbin));
      end
      tick();
      chk("done_count", (w == 8 ? n_done8 : n_done16) - base, 1000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepted start edge.
REQ-007 bin  input  1  borrow-in to bit 0; sampled on the accepted start edge.
REQ-008 busy  output  1  high while bit-serial computation runs.
REQ-009 done  output  1  single-cycle pulse when result becomes valid.
REQ-010 diff  output  WIDTH  registered difference a - b - bin, modulo 2^WIDTH.
REQ-011 borrow_out  output  1  registered borrow out of the MSB.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL latch a, b and bin, clear the bit counter to 0, and enter RUN; start=0 keeps IDLE.
REQ-014 RUN: each cycle SHALL process one bit i = counter, LSB first, through one full-subtractor cell: d = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~a[i]&br) | (b[i]&br).
REQ-015 RUN: d SHALL be shifted into an internal result shift register and br_next stored in the borrow register every RUN cycle.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1 the FSM enters DONE.
REQ-017 DONE: diff and borrow_out SHALL be updated from the internal registers on entry, done=1 for exactly that one cycle, then the FSM returns unconditionally to IDLE.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both high.
REQ-019 Latency: start sampled at edge k -> busy high cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1.
REQ-020 start asserted in RUN or DONE SHALL be ignored (no restart, no re-latch); held start is accepted again on the first IDLE edge.
REQ-021 Changes on a, b or bin after the accepted start SHALL NOT affect the result in flight.
REQ-022 diff and borrow_out SHALL hold their values from DONE until the next DONE; they are not cleared by a new start.
REQ-023 Bit counter SHALL be ceil(log2(WIDTH))+1 bits wide, with no wrap-around during RUN.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, counter=0, borrow register=0, internal result=0, diff=0, borrow_out=0, busy=0, done=0.
REQ-025 rst SHALL take priority over start in every state.
REQ-026 rst during RUN SHALL abort the operation with no done pulse, and the first post-reset start SHALL run normally.

Configuration
REQ-027 Macro SUB_OVERFLOW_EN: when defined, the block SHALL add output ovf (1 bit), registered in DONE, equal to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) for the latched operands (two's-complement overflow, bin included in diff).
REQ-028 ovf SHALL reset to 0 and hold like diff; when SUB_OVERFLOW_EN is undefined the ovf port and its logic SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-029 WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> busy 8 cycles, done in 9th cycle, diff=0x02, borrow_out=0.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow_out=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow_out=1.
REQ-031 With SUB_OVERFLOW_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1; a=0x10, b=0x01 -> diff=0x0F, ovf=0.
REQ-032 Start with a=0x05, b=0x03, then start=1 and a=0xFF, b=0x00 during busy -> single done, diff=0x02; operand change ignored.
REQ-033 rst=1 at RUN cycle 4 -> next edge busy=0, done=0, diff=0x00; no done pulse; a subsequent start with a=0x09, b=0x04 -> diff=0x05.
REQ-034 Random a, b, bin across 1000 ops at WIDTH=8 and WIDTH=16 -> {borrow_out, diff} equals a - b - bin modulo 2^(WIDTH+1) scoreboard; done count equals accepted starts.
